// File: rtl/notes_pkg.sv
// Shared note-slot definitions for the notes state loader and its consumers.
package notes_pkg;

  localparam int unsigned DEF_DISPLAYED_BEATS    = 9;
  localparam int unsigned DEF_SIMULTANEOUS_NOTES = 4;
  localparam int unsigned DEF_BEAT_BITS          = 7;
  localparam int unsigned DEF_NOTE_BITS          = 6;
  localparam int unsigned DEF_ROM_ADDR_BITS      = 10;

  localparam int unsigned NOTE_STATE_BITS  = DEF_NOTE_BITS + 2 * DEF_BEAT_BITS;
  localparam int unsigned NOTES_STATE_SIZE = 2 * DEF_DISPLAYED_BEATS * DEF_SIMULTANEOUS_NOTES;

  // Slot layout, MSB first: {note, start_beat, duration}
  typedef struct packed {
    logic [DEF_NOTE_BITS-1:0] note;
    logic [DEF_BEAT_BITS-1:0] start_beat;
    logic [DEF_BEAT_BITS-1:0] duration;
  } note_state_t;

  // Duration 0 means the slot never plays, so all-zero marks an empty slot
  localparam note_state_t EMPTY_SLOT = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    EVICT = 3'd2,
    FETCH = 3'd3,
    WAIT  = 3'd4,
    PLACE = 3'd5
  } load_state_e;

endpackage

// File: rtl/position_counter.sv
// Wrapping slot index counter shared by the CLEAR, EVICT and PLACE scans.
module position_counter #(
  parameter int unsigned COUNT    = 72,
  parameter int unsigned POS_BITS = $clog2(COUNT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                en_i,
  output logic [POS_BITS-1:0] pos_o,
  output logic                last_c_o
);

  logic [POS_BITS-1:0] pos_q, pos_d;

  assign last_c_o = (pos_q == POS_BITS'(COUNT - 1));
  assign pos_o    = pos_q;

  always_comb begin
    pos_d = pos_q;
    if (clr_i) begin
      pos_d = '0;
    end else if (en_i) begin
      pos_d = last_c_o ? '0 : pos_q + POS_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos_q <= '0;
    else        pos_q <= pos_d;
  end

endmodule

// File: rtl/notes_state_loader.sv
// Streams song ROM entries into a fixed array of note slots, keeping the lookahead window filled.
module notes_state_loader
  import notes_pkg::*;
#(
  parameter int unsigned DISPLAYED_BEATS    = DEF_DISPLAYED_BEATS,
  parameter int unsigned SIMULTANEOUS_NOTES = DEF_SIMULTANEOUS_NOTES,
  parameter int unsigned BEAT_BITS          = DEF_BEAT_BITS,
  parameter int unsigned NOTE_BITS          = DEF_NOTE_BITS,
  parameter int unsigned ROM_ADDR_BITS      = DEF_ROM_ADDR_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 song_start,
  input  logic [ROM_ADDR_BITS-1:0]             song_len,
  input  logic [BEAT_BITS-1:0]                 cur_beat,
  input  logic                                 new_beat,
  output logic [ROM_ADDR_BITS-1:0]             rom_addr,
  input  logic [NOTE_BITS+2*BEAT_BITS-1:0]     rom_data,
  output logic [2*DISPLAYED_BEATS*SIMULTANEOUS_NOTES-1:0][NOTE_BITS+2*BEAT_BITS-1:0] notes,
  output logic                                 busy,
  output logic                                 song_end,
  output logic                                 overflow
);

  localparam int unsigned SLOT_BITS = NOTE_BITS + 2 * BEAT_BITS;
  localparam int unsigned NUM_SLOTS = 2 * DISPLAYED_BEATS * SIMULTANEOUS_NOTES;
  localparam int unsigned IDX_BITS  = $clog2(NUM_SLOTS);
  localparam int unsigned EXT_BITS  = BEAT_BITS + 1;

  load_state_e                                  state_q, state_d;
  logic [ROM_ADDR_BITS-1:0]                     rom_ptr_q, rom_ptr_d;
  logic [ROM_ADDR_BITS-1:0]                     len_q, len_d;
  logic                                         pending_q, pending_d;
  logic                                         song_end_q, song_end_d;
  logic                                         overflow_q, overflow_d;
  logic [SLOT_BITS-1:0]                         entry_q, entry_d;
  logic [NUM_SLOTS-1:0][SLOT_BITS-1:0]          notes_q;

  logic                 wr_en_c;
  logic [SLOT_BITS-1:0] wr_data_c;
  logic                 cnt_clr_c, cnt_en_c;
  logic [IDX_BITS-1:0]  pos;
  logic                 pos_last_c;
  logic [SLOT_BITS-1:0] cur_slot_c;
  logic [EXT_BITS-1:0]  slot_end_c, window_end_c;
  logic                 expired_c, beyond_c, zero_dur_c, slot_empty_c;

  position_counter #(
    .COUNT    (NUM_SLOTS),
    .POS_BITS (IDX_BITS)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cnt_clr_c),
    .en_i     (cnt_en_c),
    .pos_o    (pos),
    .last_c_o (pos_last_c)
  );

  // Slot and ROM-entry field decode; sums widened one bit so they cannot wrap
  assign cur_slot_c   = notes_q[pos];
  assign slot_end_c   = {1'b0, cur_slot_c[2*BEAT_BITS-1:BEAT_BITS]} + {1'b0, cur_slot_c[BEAT_BITS-1:0]};
  assign expired_c    = (slot_end_c <= {1'b0, cur_beat});
  assign window_end_c = {1'b0, cur_beat} + EXT_BITS'(DISPLAYED_BEATS);
  assign beyond_c     = ({1'b0, rom_data[2*BEAT_BITS-1:BEAT_BITS]} >= window_end_c);
  assign zero_dur_c   = (rom_data[BEAT_BITS-1:0] == '0);
  assign slot_empty_c = (cur_slot_c == SLOT_BITS'(EMPTY_SLOT));

  always_comb begin
    state_d    = state_q;
    rom_ptr_d  = rom_ptr_q;
    len_d      = len_q;
    pending_d  = pending_q;
    song_end_d = song_end_q;
    overflow_d = overflow_q;
    entry_d    = entry_q;
    wr_en_c    = 1'b0;
    wr_data_c  = '0;

    if (new_beat && (state_q != IDLE)) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (new_beat || pending_q) begin
          state_d   = EVICT;
          pending_d = 1'b0;
        end
      end
      CLEAR: begin
        wr_en_c = 1'b1;
        if (pos_last_c) state_d = FETCH;
      end
      EVICT: begin
        wr_en_c = expired_c;
        if (pos_last_c) state_d = FETCH;
      end
      FETCH: begin
        if (rom_ptr_q < len_q) begin
          state_d = WAIT;
        end else begin
          song_end_d = 1'b1;
          state_d    = IDLE;
        end
      end
      WAIT: begin
        entry_d = rom_data;
        if (beyond_c) begin
          state_d = IDLE;
        end else if (zero_dur_c) begin
          rom_ptr_d = rom_ptr_q + ROM_ADDR_BITS'(1);
          state_d   = FETCH;
        end else begin
          state_d = PLACE;
        end
      end
      PLACE: begin
        if (slot_empty_c) begin
          wr_en_c   = 1'b1;
          wr_data_c = entry_q;
          rom_ptr_d = rom_ptr_q + ROM_ADDR_BITS'(1);
          state_d   = FETCH;
        end else if (pos_last_c) begin
          overflow_d = 1'b1;
          rom_ptr_d  = rom_ptr_q + ROM_ADDR_BITS'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new song overrides whatever is in flight, including a pending slot write
    if (song_start) begin
      state_d    = CLEAR;
      rom_ptr_d  = '0;
      len_d      = song_len;
      song_end_d = 1'b0;
      overflow_d = 1'b0;
      pending_d  = 1'b0;
      wr_en_c    = 1'b0;
    end

    cnt_clr_c = song_start || (state_d != state_q);
    cnt_en_c  = (state_q == CLEAR) || (state_q == EVICT) || (state_q == PLACE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_ptr_q  <= '0;
      len_q      <= '0;
      pending_q  <= 1'b0;
      song_end_q <= 1'b0;
      overflow_q <= 1'b0;
      entry_q    <= '0;
      notes_q    <= '0;
    end else begin
      state_q    <= state_d;
      rom_ptr_q  <= rom_ptr_d;
      len_q      <= len_d;
      pending_q  <= pending_d;
      song_end_q <= song_end_d;
      overflow_q <= overflow_d;
      entry_q    <= entry_d;
      if (wr_en_c) notes_q[pos] <= wr_data_c;
    end
  end

  assign rom_addr = rom_ptr_q;
  assign notes    = notes_q;
  assign song_end = song_end_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_notes_state_loader.sv
// Bench for notes_state_loader: directed vectors, multi-cycle corner cases and a randomized song walk.
module tb_notes_state_loader;

  localparam int unsigned DB = 9;
  localparam int unsigned SN = 4;
  localparam int unsigned BB = 7;
  localparam int unsigned NB = 6;
  localparam int unsigned AB = 10;
  localparam int unsigned SB = NB + 2 * BB;
  localparam int unsigned NS = 2 * DB * SN;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   song_start = 1'b0;
  logic                   new_beat = 1'b0;
  logic [AB-1:0]          song_len = '0;
  logic [BB-1:0]          cur_beat = '0;
  logic [AB-1:0]          rom_addr;
  logic [SB-1:0]          rom_data;
  logic [NS-1:0][SB-1:0]  notes;
  logic                   busy, song_end, overflow;

  logic [SB-1:0] rom [1024];

  int checks = 0;
  int errors = 0;

  // Reference model: the slot array and load pointer as plain variables
  logic [SB-1:0] m_slot [NS];
  int            m_ptr, m_len;
  bit            m_end, m_ovf;

  notes_state_loader #(
    .DISPLAYED_BEATS    (DB),
    .SIMULTANEOUS_NOTES (SN),
    .BEAT_BITS          (BB),
    .NOTE_BITS          (NB),
    .ROM_ADDR_BITS      (AB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .song_start (song_start),
    .song_len   (song_len),
    .cur_beat   (cur_beat),
    .new_beat   (new_beat),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .notes      (notes),
    .busy       (busy),
    .song_end   (song_end),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [SB-1:0] ent(input int n, input int s, input int d);
    return {NB'(n), BB'(s), BB'(d)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) m_slot[i] = '0;
  endtask

  task automatic model_load(input int beat);
    logic [SB-1:0] e;
    bit done, placed;
    done = 0;
    for (int g = 0; g < 2000 && !done; g++) begin
      if (m_ptr >= m_len) begin
        m_end = 1;
        done  = 1;
      end else begin
        e = rom[m_ptr];
        if (int'(e[2*BB-1:BB]) >= beat + DB) begin
          done = 1;
        end else begin
          m_ptr++;
          if (e[BB-1:0] != '0) begin
            placed = 0;
            for (int i = 0; i < NS && !placed; i++) begin
              if (m_slot[i] == '0) begin
                m_slot[i] = e;
                placed = 1;
              end
            end
            if (!placed) begin
              m_ovf = 1;
              done  = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic model_start(input int len, input int beat);
    model_clear();
    m_ptr = 0; m_len = len; m_end = 0; m_ovf = 0;
    model_load(beat);
  endtask

  task automatic model_new_beat(input int beat);
    for (int i = 0; i < NS; i++)
      if (int'(m_slot[i][2*BB-1:BB]) + int'(m_slot[i][BB-1:0]) <= beat) m_slot[i] = '0;
    model_load(beat);
  endtask

  task automatic chk_model(input string name);
    int bad, first;
    bad = 0; first = 0;
    for (int i = 0; i < NS; i++)
      if (notes[i] !== m_slot[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s notes: %0d slots differ, slot %0d got 0x%0h expected 0x%0h",
               name, bad, first, notes[first], m_slot[first]);
    end
    chk({name, " rom_addr"}, 32'(rom_addr), 32'(m_ptr));
    chk({name, " song_end"}, 32'(song_end), 32'(m_end));
    chk({name, " overflow"}, 32'(overflow), 32'(m_ovf));
    chk({name, " busy"},     32'(busy),     32'(0));
  endtask

  task automatic start_song(input int len, input int beat);
    @(negedge clk);
    song_len   = AB'(len);
    cur_beat   = BB'(beat);
    song_start = 1'b1;
    @(negedge clk);
    song_start = 1'b0;
  endtask

  task automatic beat_pulse(input int beat);
    @(negedge clk);
    cur_beat = BB'(beat);
    new_beat = 1'b1;
    @(negedge clk);
    new_beat = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL %s idle timeout: busy still %0b after %0d cycles", name, busy, n);
    end
  endtask

  task automatic count_nonzero(output int cnt);
    cnt = 0;
    for (int i = 0; i < NS; i++) if (notes[i] != '0) cnt++;
  endtask

  typedef struct {
    bit            start;
    int            beat;
    logic [SB-1:0] s0;
    logic [SB-1:0] s1;
    bit            e_end;
    int            e_ptr;
  } vec_t;

  function automatic vec_t mkvec(input bit st, input int b, input logic [SB-1:0] a0,
                                 input logic [SB-1:0] a1, input bit en, input int p);
    vec_t v;
    v.start = st; v.beat = b; v.s0 = a0; v.s1 = a1; v.e_end = en; v.e_ptr = p;
    return v;
  endfunction

  vec_t vt [5];

  initial begin
    int n, nz, len, s, b;

    for (int i = 0; i < 1024; i++) rom[i] = '0;
    model_start(0, 0);
    m_end = 0;

    // Reset state
    #12;
    chk_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: three-entry song, window and eviction behaviour
    rom[0] = ent(5, 0, 2);
    rom[1] = ent(7, 1, 1);
    rom[2] = ent(9, 20, 4);
    vt[0] = mkvec(1, 0,  ent(5, 0, 2),  ent(7, 1, 1), 0, 2);
    vt[1] = mkvec(0, 2,  '0,            '0,           0, 2);
    vt[2] = mkvec(0, 12, ent(9, 20, 4), '0,           1, 3);
    vt[3] = mkvec(0, 30, '0,            '0,           1, 3);
    vt[4] = mkvec(1, 0,  ent(5, 0, 2),  ent(7, 1, 1), 0, 2);
    for (int k = 0; k < 5; k++) begin
      if (vt[k].start) start_song(3, vt[k].beat);
      else             beat_pulse(vt[k].beat);
      wait_idle($sformatf("vec%0d", k));
      chk($sformatf("vec%0d slot0", k),    32'(notes[0]),  32'(vt[k].s0));
      chk($sformatf("vec%0d slot1", k),    32'(notes[1]),  32'(vt[k].s1));
      chk($sformatf("vec%0d slot2", k),    32'(notes[2]),  32'(0));
      chk($sformatf("vec%0d song_end", k), 32'(song_end),  32'(vt[k].e_end));
      chk($sformatf("vec%0d overflow", k), 32'(overflow),  32'(0));
      chk($sformatf("vec%0d rom_addr", k), 32'(rom_addr),  32'(vt[k].e_ptr));
      chk($sformatf("vec%0d busy", k),     32'(busy),      32'(0));
    end

    // Every slot taken, one more in-window entry is dropped
    for (int i = 0; i < NS; i++) rom[i] = ent(i + 1, 0, 50);
    rom[NS] = ent(3, 0, 5);
    model_start(NS + 1, 0);
    start_song(NS + 1, 0);
    wait_idle("overflow");
    chk_model("overflow");
    chk("overflow flag", 32'(overflow), 32'(1));
    chk("overflow ptr",  32'(rom_addr), 32'(NS + 1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("overflow cleared by reset", 32'(overflow), 32'(0));
    chk("slots cleared by reset",    32'(notes[NS-1]), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // new_beat during FETCH is held pending until IDLE, then EVICT follows
    start_song(0, 0);
    repeat (NS) @(negedge clk);
    chk("pend fetch busy", 32'(busy), 32'(1));
    new_beat = 1'b1;
    @(negedge clk);
    new_beat = 1'b0;
    chk("pend idle busy",  32'(busy),     32'(0));
    chk("pend song_end",   32'(song_end), 32'(1));
    @(negedge clk);
    chk("pend evict start", 32'(busy), 32'(1));
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("pend evict+fetch cycles", 32'(n), 32'(NS + 1));

    // Reset while PLACE is about to write slot 0 (first entry skipped for duration 0)
    rom[0] = ent(1, 0, 0);
    rom[1] = ent(5, 0, 2);
    start_song(2, 0);
    repeat (NS + 4) @(negedge clk);
    chk("place busy",     32'(busy),     32'(1));
    chk("place rom_addr", 32'(rom_addr), 32'(1));
    chk("place slot0",    32'(notes[0]), 32'(0));
    rst_n = 1'b0;
    #1;
    model_clear();
    m_ptr = 0; m_end = 0; m_ovf = 0;
    chk_model("reset in place");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("after reset slot0", 32'(notes[0]), 32'(0));
    chk("after reset busy",  32'(busy),     32'(0));

    // song_start during EVICT restarts from a fully cleared array
    rom[0] = ent(5, 0, 2);
    rom[1] = ent(7, 1, 1);
    rom[2] = ent(9, 20, 4);
    start_song(3, 0);
    wait_idle("restart load");
    beat_pulse(0);
    repeat (5) @(negedge clk);
    chk("restart in evict", 32'(busy), 32'(1));
    start_song(3, 0);
    repeat (NS) @(negedge clk);
    count_nonzero(nz);
    chk("restart cleared slots", 32'(nz),       32'(0));
    chk("restart rom_addr",      32'(rom_addr), 32'(0));
    wait_idle("restart reload");
    model_start(3, 0);
    chk_model("restart reload");

    // Randomized songs walked through with random beat advances
    for (int r = 0; r < 5; r++) begin
      len = int'($urandom_range(20, 110));
      s = 0;
      for (int i = 0; i < len; i++) begin
        if (s < 100 && $urandom_range(0, 2) == 0) s += int'($urandom_range(1, 3));
        rom[i] = ent(int'($urandom_range(0, 63)), s, int'($urandom_range(0, 12)));
      end
      model_start(len, 0);
      start_song(len, 0);
      wait_idle($sformatf("rand%0d start", r));
      chk_model($sformatf("rand%0d start", r));
      b = 0;
      for (int t = 0; t < 18; t++) begin
        b += int'($urandom_range(0, 7));
        if (b > 120) break;
        model_new_beat(b);
        beat_pulse(b);
        wait_idle($sformatf("rand%0d beat%0d", r, b));
        chk_model($sformatf("rand%0d beat%0d", r, b));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/notes_state_loader.md
NOTES_STATE_LOADER -- requirements
Module: notes_state_loader

Interface
REQ-001 SHALL have parameter DISPLAYED_BEATS, default 9, beats in the lookahead window.
REQ-002 SHALL have parameter SIMULTANEOUS_NOTES, default 4, notes per displayed beat.
REQ-003 SHALL have parameter BEAT_BITS, default 7, width of a beat number.
REQ-004 SHALL have parameter NOTE_BITS, default 6, width of a note code.
REQ-005 SHALL have parameter ROM_ADDR_BITS, default 10, song ROM address width.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port song_start  input  1  one-cycle pulse: begin loading a song from ROM address 0.
REQ-009 SHALL have port song_len  input  ROM_ADDR_BITS  number of ROM entries in the song, sampled on song_start.
REQ-010 SHALL have port cur_beat  input  BEAT_BITS  current beat in the song.
REQ-011 SHALL have port new_beat  input  1  one-cycle pulse on entering a new beat.
REQ-012 SHALL have port rom_addr  output  ROM_ADDR_BITS  song ROM read address.
REQ-013 SHALL have port rom_data  input  NOTE_STATE_BITS  {note, start_beat, duration}, valid one cycle after rom_addr.
REQ-014 SHALL have port notes  output  NOTES_STATE_SIZE x NOTE_STATE_BITS  notes state array of slots.
REQ-015 SHALL have port busy  output  1  high while not IDLE.
REQ-016 SHALL have port song_end  output  1  high once all song_len entries are placed.
REQ-017 SHALL have port overflow  output  1  sticky: an entry found no free slot.

Function
REQ-018 NOTE_STATE_BITS = NOTE_BITS+2*BEAT_BITS; NOTES_STATE_SIZE = 2*DISPLAYED_BEATS*SIMULTANEOUS_NOTES.
REQ-019 An empty slot SHALL be all-zero (duration 0, so it is never playing).
REQ-020 FSM states SHALL be IDLE, CLEAR, EVICT, FETCH, WAIT, PLACE.
REQ-021 song_start in any state SHALL go to CLEAR, set rom_ptr=0, latch song_len, clear song_end, overflow and pending.
REQ-022 CLEAR SHALL zero one slot per cycle (NOTES_STATE_SIZE cycles), then go to FETCH.
REQ-023 new_beat in IDLE SHALL go to EVICT; in any other state it SHALL set pending, which is consumed on the next return to IDLE (entering EVICT next cycle).
REQ-024 EVICT SHALL examine one slot per cycle; a slot with start_beat+duration <= cur_beat (computed in BEAT_BITS+1 bits) SHALL be zeroed; after the last slot, go to FETCH.
REQ-025 FETCH SHALL drive rom_addr=rom_ptr and go to WAIT if rom_ptr < song_len, else set song_end and go to IDLE.
REQ-026 WAIT SHALL register rom_data; if its start_beat >= cur_beat+DISPLAYED_BEATS (BEAT_BITS+1 bits), go to IDLE without advancing rom_ptr; else go to PLACE.
REQ-027 PLACE SHALL scan slots from index 0, one per cycle, and write the entry into the first empty slot, increment rom_ptr, and return to FETCH.
REQ-028 If PLACE scans all slots without finding one empty, it SHALL set overflow, increment rom_ptr (entry dropped), and go to IDLE.
REQ-029 Entries with duration 0 SHALL be skipped (rom_ptr incremented, nothing written).
REQ-030 ROM entries are in nondecreasing start_beat order; the block SHALL not reorder them.
REQ-031 notes SHALL be registered and change only by single-slot writes, so readers observe at most one slot changing per cycle.
REQ-032 busy SHALL be combinational from state (state != IDLE).

Reset
REQ-033 On rst_n low, asynchronously: state=IDLE, all slots zero, rom_ptr=0, rom_addr=0, pending=0, song_end=0, overflow=0, busy=0.
REQ-034 Reset mid-load SHALL abandon the load entirely; no partial slot write persists.

Structure
REQ-035 NOTE_STATE_BITS, NOTES_STATE_SIZE, the entry field layout and the empty-slot encoding SHALL live in shared package notes_pkg, used also by the notes consumer.
REQ-036 The slot index (CLEAR/EVICT/PLACE scans) SHALL use the existing position_counter sub-module; no other sub-module.

Verification
REQ-037 Reset then song_start, song_len=3, cur_beat=0, ROM {5,0,2},{7,1,1},{9,20,4} -> slots 0,1 hold first two entries, entry 3 not loaded, song_end=0, busy drops.
REQ-038 cur_beat=2 with new_beat -> slot 0 {5,0,2} and slot 1 {7,1,1} zeroed; cur_beat advanced to 12, new_beat -> {9,20,4} placed in slot 0.
REQ-039 All 72 slots filled with duration-50 entries, one more entry in window -> overflow=1, entry dropped, rom_ptr advances.
REQ-040 new_beat asserted during FETCH -> pending set, EVICT starts the cycle after IDLE is reached.
REQ-041 rst_n low during PLACE -> all outputs at reset values immediately, no slot written.
REQ-042 song_start while busy in EVICT -> CLEAR entered next cycle, all slots zero after 72 cycles, loading restarts at address 0.
